// File: rtl/myproject_prod_accum.sv
// Streaming product accumulator: sums N_TERMS products, scales and range-limits.
// Optional saturation of the result: define MYPROJECT_ACC_SAT_EN.
module myproject_prod_accum #(
  parameter int PROD_WIDTH = 10,
  parameter int N_TERMS    = 16,
  parameter int ACC_WIDTH  = 14,
  parameter int SHIFT      = 2,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_tdata,
  input  logic                  prod_tvalid,
  output logic                  prod_tready,
  input  logic                  prod_tlast,
  output logic [OUT_WIDTH-1:0]  res_tdata,
  output logic                  res_tvalid,
  input  logic                  res_tready,
  output logic                  err_frame
);

  localparam int CW = $clog2(N_TERMS);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   res_q, res_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;

  logic [ACC_WIDTH-1:0]   sum_w;
  logic [OUT_WIDTH-1:0]   lim_w;
  logic                   last_term;
  logic                   is_final;
  logic                   in_beat;

  assign last_term = (cnt_q == CW'(N_TERMS - 1));
  assign is_final  = prod_tlast | last_term;

  // Only a final beat needs a free output slot; it may use the one draining now.
  assign prod_tready = ~(vld_q & ~res_tready) | ~is_final;
  assign in_beat     = prod_tvalid & prod_tready;

  assign sum_w = ((state_q == S_ACC) ? acc_q : '0)
               + ACC_WIDTH'(prod_tdata);

`ifdef MYPROJECT_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] OUT_MAX =
    ACC_WIDTH'((1 << OUT_WIDTH) - 1);
  logic [ACC_WIDTH-1:0] scaled_w;
  assign scaled_w = sum_w >> SHIFT;
  assign lim_w    = (scaled_w > OUT_MAX) ? '1
                                         : scaled_w[OUT_WIDTH-1:0];
`else
  assign lim_w = OUT_WIDTH'(sum_w >> SHIFT);
`endif

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any final beat closes the frame.
  always_comb begin
    state_d = state_q;
    if (in_beat) begin
      state_d = is_final ? S_IDLE : S_ACC;
    end
  end

  // Datapath next values: accumulate, emit on final beat, drain on ready.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    vld_d = vld_q & ~res_tready;
    err_d = err_q;
    if (in_beat) begin
      if (is_final) begin
        acc_d = '0;
        cnt_d = '0;
        res_d = lim_w;
        vld_d = 1'b1;
        if (prod_tlast != last_term) begin
          err_d = 1'b1;
        end
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign res_tdata  = res_q;
  assign res_tvalid = vld_q;
  assign err_frame  = err_q;

endmodule

// File: tb/tb_myproject_prod_accum.sv
// Directed testbench for myproject_prod_accum.
// Expected results follow the saturation build option.
module tb_myproject_prod_accum;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic [9:0] prod_tdata = '0;
  logic       prod_tvalid = 1'b0;
  logic       prod_tready;
  logic       prod_tlast = 1'b0;
  logic [7:0] res_tdata;
  logic       res_tvalid;
  logic       res_tready = 1'b0;
  logic       err_frame;

  int n_checks = 0;
  int n_fail = 0;

`ifdef MYPROJECT_ACC_SAT_EN
  localparam logic [7:0] MAX_EXP = 8'd255;
`else
  localparam logic [7:0] MAX_EXP = 8'd252;
`endif

  myproject_prod_accum dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tready (prod_tready),
    .prod_tlast  (prod_tlast),
    .res_tdata   (res_tdata),
    .res_tvalid  (res_tvalid),
    .res_tready  (res_tready),
    .err_frame   (err_frame)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic send(input logic [9:0] d, input logic l);
    @(negedge ap_clk);
    prod_tdata  = d;
    prod_tvalid = 1'b1;
    prod_tlast  = l;
  endtask

  task automatic stop_in();
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    stop_in();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    #1;
    n_checks++;
    if (res_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b exp 0", res_tvalid);
    end
    n_checks++;
    if (res_tdata !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_data got %0d exp 0", res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err got %b exp 0", err_frame);
    end
    n_checks++;
    if (prod_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b exp 1", prod_tready);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    res_tready = 1'b1;
    for (int i = 1; i <= 16; i++) send(10'd4, i == 16);
    #1;
    n_checks++;
    if (res_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid got %b exp 0", res_tvalid);
    end
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd16) begin
      n_fail++;
      $display("FAIL basic_result got v=%b d=%0d exp v=1 d=16",
               res_tvalid, res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err got %b exp 0", err_frame);
    end
    stop_in();
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got %b exp 0", res_tvalid);
    end
  endtask

  task automatic test_max();
    res_tready = 1'b1;
    for (int i = 1; i <= 16; i++) send(10'd1023, i == 16);
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== MAX_EXP) begin
      n_fail++;
      $display("FAIL max_result got v=%b d=%0d exp v=1 d=%0d",
               res_tvalid, res_tdata, MAX_EXP);
    end
    stop_in();
    @(negedge ap_clk);
  endtask

  task automatic test_back_to_back();
    res_tready = 1'b0;
    for (int i = 1; i <= 16; i++) send(10'd8, i == 16);
    for (int i = 1; i <= 15; i++) begin
      send(10'd12, 1'b0);
      #1;
      n_checks++;
      if (prod_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_beat%0d got %b exp 1", i, prod_tready);
      end
      n_checks++;
      if (res_tvalid !== 1'b1 || res_tdata !== 8'd32) begin
        n_fail++;
        $display("FAIL b2b_hold_beat%0d got v=%b d=%0d exp v=1 d=32",
                 i, res_tvalid, res_tdata);
      end
    end
    send(10'd12, 1'b1);
    #1;
    n_checks++;
    if (prod_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall got %b exp 0", prod_tready);
    end
    @(negedge ap_clk);
    n_checks++;
    if (prod_tready !== 1'b0 || res_tdata !== 8'd32) begin
      n_fail++;
      $display("FAIL b2b_stall2 got r=%b d=%0d exp r=0 d=32",
               prod_tready, res_tdata);
    end
    res_tready = 1'b1;
    #1;
    n_checks++;
    if (prod_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_passthru got %b exp 1", prod_tready);
    end
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd48) begin
      n_fail++;
      $display("FAIL b2b_second got v=%b d=%0d exp v=1 d=48",
               res_tvalid, res_tdata);
    end
    stop_in();
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain got %b exp 0", res_tvalid);
    end
  endtask

  task automatic test_early_last();
    res_tready = 1'b1;
    for (int i = 1; i <= 5; i++) send(10'd40, i == 5);
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd50) begin
      n_fail++;
      $display("FAIL early_result got v=%b d=%0d exp v=1 d=50",
               res_tvalid, res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL early_err got %b exp 1", err_frame);
    end
    stop_in();
    for (int i = 1; i <= 16; i++) send(10'd4, i == 16);
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd16) begin
      n_fail++;
      $display("FAIL early_next got v=%b d=%0d exp v=1 d=16",
               res_tvalid, res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL early_sticky got %b exp 1", err_frame);
    end
    stop_in();
    @(negedge ap_clk);
  endtask

  task automatic test_missing_last();
    do_reset();
    res_tready = 1'b1;
    for (int i = 1; i <= 16; i++) send(10'd4, 1'b0);
    #1;
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_err_pre got %b exp 0", err_frame);
    end
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd16) begin
      n_fail++;
      $display("FAIL miss_result got v=%b d=%0d exp v=1 d=16",
               res_tvalid, res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_err got %b exp 1", err_frame);
    end
    stop_in();
    @(negedge ap_clk);
  endtask

  task automatic test_reset_midframe();
    res_tready = 1'b1;
    for (int i = 1; i <= 9; i++) send(10'd4, 1'b0);
    @(negedge ap_clk);
    stop_in();
    ap_rst_n = 1'b0;
    #1;
    n_checks++;
    if (res_tvalid !== 1'b0 || res_tdata !== 8'd0 ||
        err_frame !== 1'b0 || prod_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_outs got v=%b d=%0d e=%b r=%b exp 0 0 0 1",
               res_tvalid, res_tdata, err_frame, prod_tready);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_noemit got %b exp 0", res_tvalid);
    end
    for (int i = 1; i <= 16; i++) begin
      send(10'd4, i == 16);
      #1;
      n_checks++;
      if (res_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_pre_beat%0d got %b exp 0", i, res_tvalid);
      end
    end
    @(negedge ap_clk);
    n_checks++;
    if (res_tvalid !== 1'b1 || res_tdata !== 8'd16) begin
      n_fail++;
      $display("FAIL midrst_result got v=%b d=%0d exp v=1 d=16",
               res_tvalid, res_tdata);
    end
    n_checks++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_err got %b exp 0", err_frame);
    end
    stop_in();
    @(negedge ap_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
